frame_tx_scheduler: RTL and testbench
=====================================

# frame_tx_scheduler

Sequences the UDP frame generator that streams VRAM pixel bytes into Ethernet frames: it decides when each frame starts and supplies the generator's per-frame fields (segment number, clone index, auxiliary byte, VRAM start address). It walks one image as consecutive segments and sends each segment CLONES times. It chains segments using the generator's reported last address and wraps to a new image at the end of VRAM. It sits between the top-level enable/pacing logic and the frame generator, ahead of the MAC/CRC stage.

## Interface
- CLONES, 3: transmissions per segment (1..255); index_clone runs 0..CLONES-1.
- GAP_CYCLES, 16: idle clk cycles inserted after generator busy falls, before the next start (0 allowed).
- VRAM_LAST, 57600: highest valid VRAM byte-triplet address; lastaddr ≥ this ends the image.
- ADDR_W, 20: VRAM address width.
- clk  in  1  system clock.
- rst_n  in  1  reset; one clock; asynchronous, active-low.
- enable  in  1  run request; sampled only in IDLE and at end of GAP.
- gen_advance  in  1  byte-pacing strobe shared with the generator.
- gen_busy  in  1  generator busy.
- gen_lastaddr  in  ADDR_W  last VRAM address consumed by the finished frame (0 = wrapped).
- gen_start  out  1  frame start request to generator.
- segment_num  out  16  segment index within current image.
- index_clone  out  8  clone index of current segment.
- aux  out  8  image counter, increments per completed image.
- startaddr  out  ADDR_W  VRAM start address of current segment.
- frame_done  out  1  one-cycle pulse when the last clone of the last segment of an image completes.

## Operation
- States: IDLE, START, RUN, DONE, GAP.
- IDLE: gen_start=0; enable=1 -> START.
- START: gen_start=1, held until a cycle with gen_advance=1 is sampled; next cycle gen_start=0, -> RUN. Start must overlap an advance, because the generator only leaves its idle count on start·advance.
- RUN: wait for gen_busy=0, seen on a sampled edge after leaving START -> DONE.
- DONE (one cycle): compute the next fields from gen_lastaddr, which is valid here.
  - index_clone < CLONES-1: index_clone+1; segment_num and startaddr unchanged.
  - Else index_clone=0. If gen_lastaddr ≥ VRAM_LAST, or gen_lastaddr=0 with startaddr≠0: segment_num=0, startaddr=0, aux+1 (mod 256), frame_done=1. Otherwise startaddr=gen_lastaddr+1 and segment_num+1.
  - -> GAP.
- GAP: count GAP_CYCLES. At expiry, enable=1 -> START, else -> IDLE. Fields are retained, so resume continues at the next segment.
- segment_num, index_clone, aux and startaddr are stable from START entry through the end of RUN. They change only in DONE.
- enable dropped in START or RUN: the current frame completes normally, including DONE and GAP, then -> IDLE.
- segment_num wraps at 2^16 silently. Arithmetic on startaddr is ADDR_W-bit unsigned.

## Timing
- Reset (async assert, sync release): state IDLE; all outputs 0.
- Reset mid-frame: gen_start drops immediately. The generator is not reset by this block; the next START waits in RUN for that generator's busy to fall before anything is computed.
- gen_start rises on the clock after IDLE sees enable=1, or the clock after GAP expiry.
- gen_start deasserts 1 cycle after the sampled gen_advance. If gen_advance is already high on START entry, gen_start stays high exactly 1 cycle.
- Inter-frame: gen_busy fall -> DONE at +1 -> GAP_CYCLES cycles -> gen_start at +GAP_CYCLES+2.
- frame_done is asserted in the DONE cycle only.

## Structure
- Shared package tx_pkg: state enum, ADDR_W, VRAM_LAST, and the generator field widths (segment 16, clone 8, aux 8). The generator uses the same constants.
- No sub-module is needed. The gap counter is an inline $clog2(GAP_CYCLES+1)-bit down-counter.

## Test plan
- CLONES=3, generator model with a 1145-cycle busy and lastaddr=359: three frames with index_clone 0,1,2 at startaddr 0; fourth frame has segment_num=1, startaddr=360.
- gen_advance every 8 cycles, enable raised 3 cycles before an advance: gen_start is high 4 cycles and falls 1 cycle after the advance.
- Model returns lastaddr=57600 on the last clone: frame_done pulses once; next frame has segment_num=0, startaddr=0, aux incremented 0->1.
- Model returns lastaddr=0 with startaddr=57240: frame_done pulses and the image wraps, the same as the previous case.
- enable dropped mid-RUN: frame completes, GAP runs, state returns to IDLE. Re-enabling resumes with the next clone/segment fields, and no field is reset.
- rst_n asserted in RUN: all outputs 0 immediately; after release with enable=1, the first frame is segment 0, clone 0, startaddr 0.

Source files
------------

// File: rtl/tx_pkg.sv
// ---------------------------------------------------------------------------
// tx_pkg
// Constants and types shared by the frame transmit scheduler and the UDP
// frame generator it drives.
//   TX_ADDR_W    : VRAM byte-triplet address width
//   TX_VRAM_LAST : highest valid VRAM address; a frame ending at or past
//                  this address closes the image
//   SEG_W/CLONE_W/AUX_W : widths of the per-frame header fields
//   tx_state_e   : scheduler sequencing states
// ---------------------------------------------------------------------------
package tx_pkg;

    localparam int TX_ADDR_W    = 20;
    localparam int TX_VRAM_LAST = 57600;

    localparam int SEG_W   = 16;
    localparam int CLONE_W = 8;
    localparam int AUX_W   = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_RUN   = 3'd2,
        ST_DONE  = 3'd3,
        ST_GAP   = 3'd4
    } tx_state_e;

endpackage

// File: rtl/frame_tx_scheduler.sv
// ---------------------------------------------------------------------------
// frame_tx_scheduler
// Decides when the UDP frame generator starts each frame and supplies the
// per-frame header fields. An image is sent as consecutive VRAM segments,
// each segment CLONES times; segments are chained from the generator's
// reported last address, and the image wraps at the end of VRAM.
//
// Ports
//   clk          : system clock
//   rst_n        : asynchronous active-low reset
//   enable       : run request, looked at in IDLE and at the end of GAP
//   gen_advance  : byte-pacing strobe shared with the generator
//   gen_busy     : generator busy
//   gen_lastaddr : last VRAM address consumed by the finished frame
//   gen_start    : frame start request (held until it overlaps an advance)
//   segment_num  : segment index within the current image
//   index_clone  : clone index of the current segment
//   aux          : image counter
//   startaddr    : VRAM start address of the current segment
//   frame_done   : one-cycle pulse when an image completes
// ---------------------------------------------------------------------------
module frame_tx_scheduler
    import tx_pkg::*;
#(
    parameter int CLONES     = 3,
    parameter int GAP_CYCLES = 16,
    parameter int VRAM_LAST  = TX_VRAM_LAST,
    parameter int ADDR_W     = TX_ADDR_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    input  logic               gen_advance,
    input  logic               gen_busy,
    input  logic [ADDR_W-1:0]  gen_lastaddr,
    output logic               gen_start,
    output logic [SEG_W-1:0]   segment_num,
    output logic [CLONE_W-1:0] index_clone,
    output logic [AUX_W-1:0]   aux,
    output logic [ADDR_W-1:0]  startaddr,
    output logic               frame_done
);

    // A zero-length gap still needs a legal one-bit counter.
    localparam int CNT_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

    localparam logic [ADDR_W-1:0]  LAST_ADDR  = ADDR_W'(VRAM_LAST);
    localparam logic [CLONE_W-1:0] LAST_CLONE = CLONE_W'(CLONES - 1);
    // GAP is entered after DONE, so it holds GAP_CYCLES cycles when the
    // counter is loaded with GAP_CYCLES-1 and exits on reaching zero.
    localparam logic [CNT_W-1:0]   GAP_LOAD   = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    tx_state_e          state_q, state_d;
    logic [SEG_W-1:0]   seg_q,   seg_d;
    logic [CLONE_W-1:0] clone_q, clone_d;
    logic [AUX_W-1:0]   aux_q,   aux_d;
    logic [ADDR_W-1:0]  addr_q,  addr_d;
    logic [CNT_W-1:0]   gap_q,   gap_d;

    logic lastClone;
    logic imageEnd;

    // The image ends when the generator ran to (or past) the end of VRAM, or
    // reports address 0 (its own wrap) for a segment that did not start at 0.
    assign lastClone = (clone_q == LAST_CLONE);
    assign imageEnd  = (gen_lastaddr >= LAST_ADDR) ||
                       ((gen_lastaddr == '0) && (addr_q != '0));

    // Sequencing and field update. Fields only move in DONE, so they are
    // stable for the whole START/RUN window the generator latches them in.
    always_comb begin
        state_d = state_q;
        seg_d   = seg_q;
        clone_d = clone_q;
        aux_d   = aux_q;
        addr_d  = addr_q;
        gap_d   = gap_q;

        unique case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d = ST_START;
                end
            end

            // The generator only leaves its idle count on start and advance
            // together, so start is held until an advance is seen.
            ST_START: begin
                if (gen_advance) begin
                    state_d = ST_RUN;
                end
            end

            ST_RUN: begin
                if (!gen_busy) begin
                    state_d = ST_DONE;
                end
            end

            ST_DONE: begin
                if (!lastClone) begin
                    clone_d = clone_q + 1'b1;
                end else begin
                    clone_d = '0;
                    if (imageEnd) begin
                        seg_d  = '0;
                        addr_d = '0;
                        aux_d  = aux_q + 1'b1;
                    end else begin
                        seg_d  = seg_q + 1'b1;
                        addr_d = gen_lastaddr + 1'b1;
                    end
                end

                if (GAP_CYCLES == 0) begin
                    state_d = enable ? ST_START : ST_IDLE;
                end else begin
                    gap_d   = GAP_LOAD;
                    state_d = ST_GAP;
                end
            end

            ST_GAP: begin
                if (gap_q == '0) begin
                    state_d = enable ? ST_START : ST_IDLE;
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and field registers; reset clears everything and drops start
    // at once, leaving the generator to finish whatever it was doing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            seg_q   <= '0;
            clone_q <= '0;
            aux_q   <= '0;
            addr_q  <= '0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            seg_q   <= seg_d;
            clone_q <= clone_d;
            aux_q   <= aux_d;
            addr_q  <= addr_d;
            gap_q   <= gap_d;
        end
    end

    assign gen_start   = (state_q == ST_START);
    assign frame_done  = (state_q == ST_DONE) && lastClone && imageEnd;
    assign segment_num = seg_q;
    assign index_clone = clone_q;
    assign aux         = aux_q;
    assign startaddr   = addr_q;

endmodule

// File: tb/tb_frame_tx_scheduler.sv
// ---------------------------------------------------------------------------
// tb_frame_tx_scheduler
// Directed bench for frame_tx_scheduler with a behavioural frame generator.
// Expected per-frame fields are queued when a frame is requested and checked
// when the scheduler's start overlaps an advance.
// ---------------------------------------------------------------------------
module tb_frame_tx_scheduler;

    localparam int CLONES   = 3;
    localparam int GAP      = 16;
    localparam int AW       = 20;
    localparam int VL       = 57600;
    localparam int BUSY_LEN = 1145;

    typedef struct {
        logic [15:0]   seg;
        logic [7:0]    clone;
        logic [7:0]    aux;
        logic [AW-1:0] addr;
    } frame_t;

    logic          clk = 1'b0;
    logic          rstN;
    logic          enable;
    logic          genAdvance;
    logic          genBusy = 1'b0;
    logic [AW-1:0] genLast = '0;
    logic          genStart;
    logic [15:0]   segmentNum;
    logic [7:0]    indexClone;
    logic [7:0]    auxOut;
    logic [AW-1:0] startAddr;
    logic          frameDone;

    int testCount = 0;
    int failCount = 0;
    int cyc       = 0;
    int advCnt    = 0;
    int fdCount   = 0;
    int busyCnt   = 0;
    logic [AW-1:0] curLast = '0;

    frame_t        expQ[$];
    logic [AW-1:0] lastQ[$];
    frame_t        monExp;

    frame_tx_scheduler #(
        .CLONES     (CLONES),
        .GAP_CYCLES (GAP),
        .VRAM_LAST  (VL),
        .ADDR_W     (AW)
    ) dut (
        .clk          (clk),
        .rst_n        (rstN),
        .enable       (enable),
        .gen_advance  (genAdvance),
        .gen_busy     (genBusy),
        .gen_lastaddr (genLast),
        .gen_start    (genStart),
        .segment_num  (segmentNum),
        .index_clone  (indexClone),
        .aux          (auxOut),
        .startaddr    (startAddr),
        .frame_done   (frameDone)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Byte-pacing strobe: one advance every 8 cycles.
    assign genAdvance = (advCnt == 7);
    always @(posedge clk) begin
        advCnt <= (advCnt + 1) % 8;
        cyc    <= cyc + 1;
    end

    // Generator model: accepts a frame on start and advance while idle, stays
    // busy BUSY_LEN cycles, then reports the queued last address. It ignores
    // the scheduler's reset, as the real generator does.
    always @(posedge clk) begin
        if (!genBusy && genStart && genAdvance) begin
            genBusy <= 1'b1;
            busyCnt <= BUSY_LEN - 1;
            if (lastQ.size() > 0) begin
                curLast <= lastQ.pop_front();
            end else begin
                curLast <= AW'(359);
            end
        end else if (genBusy) begin
            if (busyCnt == 0) begin
                genBusy <= 1'b0;
                genLast <= curLast;
            end else begin
                busyCnt <= busyCnt - 1;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0d required %0d", tag, obs, exp);
        end
    endtask

    // Scoreboard monitor: on every start/advance overlap compare the fields
    // the generator would latch against the oldest queued expectation.
    always @(negedge clk) begin
        if (frameDone) begin
            fdCount++;
        end
        if (genStart && genAdvance) begin
            if (expQ.size() == 0) begin
                testCount++;
                failCount++;
                $error("[TB] FAIL unexpectedStart: observed start with seg %0d clone %0d, required none",
                       segmentNum, indexClone);
            end else begin
                monExp = expQ.pop_front();
                checkOutput("frame.seg",   32'(segmentNum), 32'(monExp.seg));
                checkOutput("frame.clone", 32'(indexClone), 32'(monExp.clone));
                checkOutput("frame.aux",   32'(auxOut),     32'(monExp.aux));
                checkOutput("frame.addr",  32'(startAddr),  32'(monExp.addr));
            end
        end
    end

    task automatic pushFrame(input int seg, input int clone, input int aux, input int addr,
                             input bit useLast, input int last);
        frame_t f;
        f.seg   = 16'(seg);
        f.clone = 8'(clone);
        f.aux   = 8'(aux);
        f.addr  = AW'(addr);
        expQ.push_back(f);
        if (useLast) begin
            lastQ.push_back(AW'(last));
        end
    endtask

    task automatic waitPop();
        for (int i = 0; i < 3000 && expQ.size() != 0; i++) begin
            @(negedge clk);
        end
        if (expQ.size() != 0) begin
            testCount++;
            failCount++;
            $error("[TB] FAIL startTimeout: observed %0d pending frames, required 0", expQ.size());
            expQ.delete();
        end
    endtask

    task automatic applyStimulus(input int seg, input int clone, input int aux, input int addr,
                                 input int last);
        pushFrame(seg, clone, aux, addr, 1'b1, last);
        waitPop();
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, ".gen_start"},   32'(genStart),   0);
        checkOutput({tag, ".segment_num"}, 32'(segmentNum), 0);
        checkOutput({tag, ".index_clone"}, 32'(indexClone), 0);
        checkOutput({tag, ".aux"},         32'(auxOut),     0);
        checkOutput({tag, ".startaddr"},   32'(startAddr),  0);
        checkOutput({tag, ".frame_done"},  32'(frameDone),  0);
    endtask

    // Directed sequence.
    initial begin
        int width;
        int tFall;
        int tRise;
        bit seen;

        rstN   = 1'b0;
        enable = 1'b0;
        repeat (3) @(negedge clk);
        checkAllZero("reset");
        rstN = 1'b1;
        repeat (2) @(negedge clk);

        // Frame 1: raise enable so the fourth START cycle carries the advance.
        pushFrame(0, 0, 0, 0, 1'b1, 359);
        for (int i = 0; i < 16 && advCnt != 3; i++) @(negedge clk);
        enable = 1'b1;
        width = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (genStart) width++;
        end
        checkOutput("startWidth", 32'(width), 4);
        waitPop();

        // Frame 2 and inter-frame spacing from busy fall to next start.
        pushFrame(0, 1, 0, 0, 1'b1, 359);
        for (int i = 0; i < 50 && !genBusy; i++) @(negedge clk);
        for (int i = 0; i < 1300 && genBusy; i++) @(negedge clk);
        tFall = cyc;
        for (int i = 0; i < 100 && !genStart; i++) @(negedge clk);
        tRise = cyc;
        checkOutput("gapSpacing", 32'(tRise - tFall), 32'(GAP + 2));
        waitPop();

        // Segment chaining and end-of-VRAM wrap.
        applyStimulus(0, 2, 0, 0,   359);
        applyStimulus(1, 0, 0, 360, 719);
        applyStimulus(1, 1, 0, 360, 719);
        applyStimulus(1, 2, 0, 360, VL);
        applyStimulus(0, 0, 1, 0,   57239);
        checkOutput("frameDoneImage1", 32'(fdCount), 1);

        // Wrap signalled by a zero last address from a non-zero segment.
        applyStimulus(0, 1, 1, 0,     57239);
        applyStimulus(0, 2, 1, 0,     57239);
        applyStimulus(1, 0, 1, 57240, 0);
        applyStimulus(1, 1, 1, 57240, 0);
        applyStimulus(1, 2, 1, 57240, 0);
        applyStimulus(0, 0, 2, 0,     359);
        checkOutput("frameDoneImage2", 32'(fdCount), 2);

        // Enable dropped mid-RUN: frame finishes, then the block idles.
        enable = 1'b0;
        seen = 1'b0;
        repeat (1400) begin
            @(negedge clk);
            if (genStart) seen = 1'b1;
        end
        checkOutput("idleAfterDrop", 32'(seen), 0);
        checkOutput("retainedClone", 32'(indexClone), 1);

        // Re-enable resumes with the next clone.
        enable = 1'b1;
        applyStimulus(0, 1, 2, 0, 359);

        // Reset while the generator is mid-frame.
        repeat (100) @(negedge clk);
        rstN = 1'b0;
        #1;
        checkAllZero("midReset");
        @(negedge clk);
        pushFrame(0, 0, 0, 0, 1'b0, 0);
        rstN = 1'b1;
        waitPop();
        enable = 1'b0;
        repeat (1400) @(negedge clk);
        checkOutput("noSpuriousDone", 32'(fdCount), 2);
        checkOutput("postResetClone", 32'(indexClone), 1);
        checkOutput("scoreboardEmpty", 32'(expQ.size()), 0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
